// File: rtl/ultrasonic_pkg.sv
// Shared types and defaults for the ultrasonic ranger scheduler.
package ultrasonic_pkg;

    // Ping-cycle states; IDLE is encoded as zero so a cleared register is idle.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    localparam int DEF_N_CH           = 4;
    localparam int DEF_DIST_W         = 32;
    localparam int DEF_TRIG_CYCLES    = 250;
    localparam int DEF_TIMEOUT_CYCLES = 25000;
    localparam int DEF_MAX_ECHO       = 600000;
    localparam int DEF_HOLDOFF_CYCLES = 1500000;

    // All-ones pattern of the given width (up to 64 bits), used as the timeout marker.
    function automatic logic [63:0] dist_sat(input int width);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for one raw echo pin plus a delayed copy for edge detection.
module echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic echo_in,
    output logic echo_s,
    output logic echo_prev
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next values: shift the pin through the synchronizer and the edge register.
    always_comb begin
        meta_d = echo_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer and edge-register flops, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign echo_s    = sync_q;
    assign echo_prev = prev_q;

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin ping scheduler sharing one echo-timing counter across N_CH rangers.
// Handshake: Done is a one-cycle strobe qualifying DoneCh and the freshly stored
// Dist/Fault of that channel; there is no back-pressure, consumers must capture it.
module ultrasonic_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int N_CH           = DEF_N_CH,
    parameter int DIST_W         = DEF_DIST_W,
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_ECHO       = DEF_MAX_ECHO,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Enable,
    input  logic [N_CH-1:0]          Echo,
    output logic [N_CH-1:0]          Trig,
    output logic [N_CH*DIST_W-1:0]   Dist,
    output logic [N_CH-1:0]          Valid,
    output logic [N_CH-1:0]          Fault,
    output logic                     Done,
    output logic [$clog2(N_CH)-1:0]  DoneCh,
    output logic                     Busy,
    output logic [2:0]               dbg_state
);

    localparam int CH_W    = $clog2(N_CH);
    localparam int M1      = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
    localparam int M2      = (M1 > MAX_ECHO) ? M1 : MAX_ECHO;
    localparam int CNT_MAX = (M2 > HOLDOFF_CYCLES) ? M2 : HOLDOFF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ECHO_CAP     = CNT_W'(MAX_ECHO);
    localparam logic [DIST_W-1:0] DIST_ONES    = DIST_W'(dist_sat(DIST_W));
    localparam logic [DIST_W-1:0] DIST_CAP     = DIST_W'(MAX_ECHO);
    localparam logic [CH_W-1:0]   CH_LAST      = CH_W'(N_CH - 1);

    logic [N_CH-1:0] echo_s;
    logic [N_CH-1:0] echo_prev;

    for (genvar k = 0; k < N_CH; k++) begin : g_sync
        echo_sync u_sync (
            .clk       (Clock),
            .rst       (Reset),
            .echo_in   (Echo[k]),
            .echo_s    (echo_s[k]),
            .echo_prev (echo_prev[k])
        );
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [DIST_W-1:0]  dist_q [N_CH];
    logic [DIST_W-1:0]  dist_d [N_CH];
    logic [N_CH-1:0]    valid_q, valid_d;
    logic [N_CH-1:0]    fault_q, fault_d;
    logic               done_q, done_d;
    logic [CH_W-1:0]    done_ch_q, done_ch_d;

    logic               echo_cur;
    logic               echo_rise;
    logic               store;
    logic [DIST_W-1:0]  store_val;
    logic               store_fault;

    assign echo_cur  = echo_s[ch_q];
    assign echo_rise = echo_s[ch_q] & ~echo_prev[ch_q];

    // Ping sequencing: next state, shared counter, channel pointer and result stores.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        dist_d      = dist_q;
        valid_d     = valid_q;
        fault_d     = fault_q;
        done_d      = 1'b0;
        done_ch_d   = done_ch_q;
        store       = 1'b0;
        store_val   = '0;
        store_fault = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    state_d = ST_TRIG;
                    cnt_d   = '0;
                end
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_RISE: begin
                // A rise in the final timeout cycle still starts a measurement.
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q == TIMEOUT_LAST) begin
                    store       = 1'b1;
                    store_val   = DIST_ONES;
                    store_fault = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MEASURE: begin
                // The fall is checked first so a fall at the cap is a clean result.
                if (!echo_cur) begin
                    store     = 1'b1;
                    store_val = DIST_W'(cnt_q);
                end else if (cnt_q == ECHO_CAP) begin
                    store       = 1'b1;
                    store_val   = DIST_CAP;
                    store_fault = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
                    state_d = Enable ? ST_TRIG : ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (store) begin
            dist_d[ch_q]  = store_val;
            fault_d[ch_q] = store_fault;
            valid_d[ch_q] = 1'b1;
            done_d        = 1'b1;
            done_ch_d     = ch_q;
            state_d       = ST_HOLDOFF;
            cnt_d         = '0;
        end
    end

    // State, counter and result registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            valid_q   <= '0;
            fault_q   <= '0;
            done_q    <= 1'b0;
            done_ch_q <= '0;
            for (int k = 0; k < N_CH; k++) dist_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            done_q    <= done_d;
            done_ch_q <= done_ch_d;
            for (int k = 0; k < N_CH; k++) dist_q[k] <= dist_d[k];
        end
    end

    // Output decode: trigger for the current channel and packed distance bus.
    always_comb begin
        Trig = '0;
        if (state_q == ST_TRIG) Trig[ch_q] = 1'b1;
        Dist = '0;
        for (int k = 0; k < N_CH; k++) Dist[k*DIST_W +: DIST_W] = dist_q[k];
    end

    assign Valid     = valid_q;
    assign Fault     = fault_q;
    assign Done      = done_q;
    assign DoneCh    = done_ch_q;
    assign Busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with a two-channel, short-timing configuration.
module tb_ultrasonic_scheduler;

    logic        Clock;
    logic        Reset;
    logic        Enable;
    logic [1:0]  Echo;
    logic [1:0]  Trig;
    logic [63:0] Dist;
    logic [1:0]  Valid;
    logic [1:0]  Fault;
    logic        Done;
    logic [0:0]  DoneCh;
    logic        Busy;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int onehot_bad = 0;

    ultrasonic_scheduler #(
        .N_CH(2), .DIST_W(32), .TRIG_CYCLES(5), .TIMEOUT_CYCLES(100),
        .MAX_ECHO(1000), .HOLDOFF_CYCLES(20)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Echo(Echo),
        .Trig(Trig), .Dist(Dist), .Valid(Valid), .Fault(Fault),
        .Done(Done), .DoneCh(DoneCh), .Busy(Busy), .dbg_state(dbg_state)
    );

    // Clock and global runaway guard.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge Clock) begin
        if (!$onehot0(Trig)) onehot_bad++;
    end

    // Runs one ping on channel ch: waits for a trigger, measures it, then drives
    // the echo pins relative to the trigger fall (t=0) until Done or budget expiry.
    task automatic do_ping(input int ch, input int pre_len, input int delay, input int len,
                           input int oth_delay, input int oth_len, input int drop_at,
                           output logic [1:0] trig_seen, output int trig_wait,
                           output int trig_w, output int done_cyc);
        int oth;
        oth = 1 - ch;
        trig_wait = 0;
        trig_w = 0;
        done_cyc = -1;
        Echo[ch] = (pre_len > 0);
        while (Trig == 2'b00 && trig_wait < 200) begin
            @(negedge Clock);
            trig_wait++;
        end
        trig_seen = Trig;
        if (Trig != 2'b00) begin
            trig_w = 1;
            do begin
                @(negedge Clock);
                if (Trig != 2'b00) trig_w++;
            end while (Trig != 2'b00 && trig_w < 50);
            for (int t = 0; t < 1600; t++) begin
                Echo[ch]  = (t < pre_len) || (t >= delay && t < delay + len);
                Echo[oth] = (t >= oth_delay && t < oth_delay + oth_len);
                if (t == drop_at) Enable = 1'b0;
                @(negedge Clock);
                if (Done) begin
                    done_cyc = t + 1;
                    break;
                end
            end
        end
        Echo = 2'b00;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Enable = 1'b0; Echo = 2'b00;
        repeat (3) @(negedge Clock);
        checks++; if (Trig !== 2'b00) begin errors++; $display("FAIL reset_trig: got %b want 00", Trig); end
        checks++; if (Dist !== 64'd0) begin errors++; $display("FAIL reset_dist: got %h want 0", Dist); end
        checks++; if (Valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", Valid); end
        checks++; if (Fault !== 2'b00) begin errors++; $display("FAIL reset_fault: got %b want 00", Fault); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
        checks++; if (DoneCh !== 1'b0) begin errors++; $display("FAIL reset_donech: got %b want 0", DoneCh); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        Reset = 1'b0;
        repeat (4) @(negedge Clock);
        checks++; if (Busy !== 1'b0 || Trig !== 2'b00) begin errors++; $display("FAIL idle_hold: busy %b trig %b want 0 00", Busy, Trig); end
    endtask

    task automatic test_first_ping();
        logic [1:0] seen; int tw, w, dc;
        Enable = 1'b1;
        do_ping(0, 0, 10, 246, 0, 0, -1, seen, tw, w, dc);
        checks++; if (seen !== 2'b01) begin errors++; $display("FAIL p1_trig_ch: got %b want 01", seen); end
        checks++; if (w !== 5) begin errors++; $display("FAIL p1_trig_width: got %0d want 5", w); end
        checks++; if (dc !== 259) begin errors++; $display("FAIL p1_done_time: got %0d want 259", dc); end
        checks++; if (Dist[31:0] !== 32'd246) begin errors++; $display("FAIL p1_dist0: got %0d want 246", Dist[31:0]); end
        checks++; if (Dist[63:32] !== 32'd0) begin errors++; $display("FAIL p1_dist1: got %0d want 0", Dist[63:32]); end
        checks++; if (Valid !== 2'b01) begin errors++; $display("FAIL p1_valid: got %b want 01", Valid); end
        checks++; if (Fault[0] !== 1'b0) begin errors++; $display("FAIL p1_fault0: got %b want 0", Fault[0]); end
        checks++; if (DoneCh !== 1'b0) begin errors++; $display("FAIL p1_donech: got %b want 0", DoneCh); end
        @(negedge Clock);
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL p1_done_pulse: got %b want 0", Done); end
    endtask

    task automatic test_timeout_wrap();
        logic [1:0] seen; int tw, w, dc;
        do_ping(1, 0, 0, 0, 0, 0, -1, seen, tw, w, dc);
        checks++; if (tw !== 19) begin errors++; $display("FAIL to_holdoff: got %0d want 19", tw); end
        checks++; if (seen !== 2'b10) begin errors++; $display("FAIL to_trig_ch: got %b want 10", seen); end
        checks++; if (w !== 5) begin errors++; $display("FAIL to_trig_width: got %0d want 5", w); end
        checks++; if (dc !== 100) begin errors++; $display("FAIL to_done_time: got %0d want 100", dc); end
        checks++; if (Dist[63:32] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_dist1: got %h want ffffffff", Dist[63:32]); end
        checks++; if (Dist[31:0] !== 32'd246) begin errors++; $display("FAIL to_dist0_hold: got %0d want 246", Dist[31:0]); end
        checks++; if (Fault !== 2'b10) begin errors++; $display("FAIL to_fault: got %b want 10", Fault); end
        checks++; if (Valid !== 2'b11) begin errors++; $display("FAIL to_valid: got %b want 11", Valid); end
        checks++; if (DoneCh !== 1'b1) begin errors++; $display("FAIL to_donech: got %b want 1", DoneCh); end
    endtask

    task automatic test_overflow_recover();
        logic [1:0] seen; int tw, w, dc;
        do_ping(0, 0, 0, 1500, 0, 0, -1, seen, tw, w, dc);
        checks++; if (tw !== 20) begin errors++; $display("FAIL ov_holdoff: got %0d want 20", tw); end
        checks++; if (seen !== 2'b01) begin errors++; $display("FAIL ov_wrap_ch: got %b want 01", seen); end
        checks++; if (dc !== 1003) begin errors++; $display("FAIL ov_done_time: got %0d want 1003", dc); end
        checks++; if (Dist[31:0] !== 32'd1000) begin errors++; $display("FAIL ov_dist0: got %0d want 1000", Dist[31:0]); end
        checks++; if (Fault[0] !== 1'b1) begin errors++; $display("FAIL ov_fault0: got %b want 1", Fault[0]); end
        checks++; if (DoneCh !== 1'b0) begin errors++; $display("FAIL ov_donech: got %b want 0", DoneCh); end
        do_ping(1, 0, 0, 0, 0, 0, -1, seen, tw, w, dc);
        checks++; if (dc !== 100 || DoneCh !== 1'b1) begin errors++; $display("FAIL ov_ch1_timeout: got %0d/%b want 100/1", dc, DoneCh); end
        do_ping(0, 0, 30, 107, 0, 0, -1, seen, tw, w, dc);
        checks++; if (dc !== 140) begin errors++; $display("FAIL rc_done_time: got %0d want 140", dc); end
        checks++; if (Dist[31:0] !== 32'd107) begin errors++; $display("FAIL rc_dist0: got %0d want 107", Dist[31:0]); end
        checks++; if (Fault[0] !== 1'b0) begin errors++; $display("FAIL rc_fault0: got %b want 0", Fault[0]); end
    endtask

    task automatic test_stale_echo();
        logic [1:0] seen; int tw, w, dc;
        do_ping(1, 0, 0, 0, 0, 0, -1, seen, tw, w, dc);
        do_ping(0, 8, 20, 50, 5, 30, -1, seen, tw, w, dc);
        checks++; if (seen !== 2'b01) begin errors++; $display("FAIL st_trig_ch: got %b want 01", seen); end
        checks++; if (dc !== 73) begin errors++; $display("FAIL st_done_time: got %0d want 73", dc); end
        checks++; if (Dist[31:0] !== 32'd50) begin errors++; $display("FAIL st_dist0: got %0d want 50", Dist[31:0]); end
        checks++; if (Fault !== 2'b10) begin errors++; $display("FAIL st_fault: got %b want 10", Fault); end
        checks++; if (Dist[63:32] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL st_dist1_hold: got %h want ffffffff", Dist[63:32]); end
        checks++; if (DoneCh !== 1'b0) begin errors++; $display("FAIL st_donech: got %b want 0", DoneCh); end
    endtask

    task automatic test_enable_drop();
        logic [1:0] seen; int tw, w, dc; int active;
        do_ping(1, 0, 0, 0, 0, 0, -1, seen, tw, w, dc);
        do_ping(0, 0, 10, 666, 0, 0, 300, seen, tw, w, dc);
        checks++; if (dc !== 679) begin errors++; $display("FAIL ed_done_time: got %0d want 679", dc); end
        checks++; if (Dist[31:0] !== 32'd666) begin errors++; $display("FAIL ed_dist0: got %0d want 666", Dist[31:0]); end
        repeat (19) @(negedge Clock);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL ed_busy_holdoff: got %b want 1", Busy); end
        @(negedge Clock);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ed_busy_idle: got %b want 0", Busy); end
        active = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clock);
            if (Trig != 2'b00 || Busy) active++;
        end
        checks++; if (active !== 0) begin errors++; $display("FAIL ed_stays_idle: got %0d active cycles want 0", active); end
    endtask

    task automatic test_reset_mid();
        int wait_c; int w; int seen_done;
        Enable = 1'b1;
        wait_c = 0;
        while (Trig == 2'b00 && wait_c < 5) begin @(negedge Clock); wait_c++; end
        checks++; if (Trig !== 2'b10) begin errors++; $display("FAIL rm_resume_ch: got %b want 10", Trig); end
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        checks++; if (Trig !== 2'b00 || Busy !== 1'b0) begin errors++; $display("FAIL rm_trig_drop: trig %b busy %b want 00 0", Trig, Busy); end
        checks++; if (Dist !== 64'd0 || Valid !== 2'b00 || Fault !== 2'b00) begin errors++; $display("FAIL rm_results: dist %h valid %b fault %b want 0", Dist, Valid, Fault); end
        checks++; if (Done !== 1'b0 || DoneCh !== 1'b0) begin errors++; $display("FAIL rm_done: done %b ch %b want 0 0", Done, DoneCh); end
        Reset = 1'b0;
        @(negedge Clock);
        checks++; if (Trig !== 2'b01) begin errors++; $display("FAIL rm_restart_ch0: got %b want 01", Trig); end
        w = 0;
        while (Trig != 2'b00 && w < 20) begin @(negedge Clock); w++; end
        Echo[0] = 1'b1;
        repeat (20) @(negedge Clock);
        checks++; if (dbg_state !== 3'd3) begin errors++; $display("FAIL rm_in_measure: got %0d want 3", dbg_state); end
        Reset = 1'b1;
        @(negedge Clock);
        checks++; if (Busy !== 1'b0 || Done !== 1'b0 || Valid !== 2'b00 || Dist !== 64'd0) begin errors++; $display("FAIL rm_measure_reset: busy %b done %b valid %b dist %h want 0", Busy, Done, Valid, Dist); end
        Reset = 1'b0; Enable = 1'b0; Echo = 2'b00;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (Done || Busy) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL rm_quiet: got %0d active cycles want 0", seen_done); end
    endtask

    task automatic test_trig_onehot();
        checks++; if (onehot_bad !== 0) begin errors++; $display("FAIL trig_onehot: got %0d bad cycles want 0", onehot_bad); end
    endtask

    initial begin
        Reset = 1'b1; Enable = 1'b0; Echo = 2'b00;
        @(negedge Clock);
        test_reset();
        test_first_ping();
        test_timeout_wrap();
        test_overflow_recover();
        test_stale_echo();
        test_enable_drop();
        test_reset_mid();
        test_trig_onehot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
